// File: rtl/ip_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_pkg
// Description : Shared types and constants for the IPv4 transmit block:
//               FSM state encoding, fixed header field values, and helpers
//               that build the 20-byte header and its ones-complement sum.
// Revision    : 1.0 - initial release
// ============================================================================
package ip_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARP  = 3'd1,
    S_CSUM = 3'd2,
    S_HDR  = 3'd3,
    S_PAY  = 3'd4
  } state_t;

  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [15:0] IP_FLAGS      = 16'h4000;

  // Header byte at position idx (0..19), transmitted big-endian.
  function automatic logic [7:0] hdr_byte(
    input logic [4:0]  idx,
    input logic [15:0] tlen,
    input logic [15:0] ident,
    input logic [7:0]  ttl,
    input logic [7:0]  proto,
    input logic [15:0] csum,
    input logic [31:0] src,
    input logic [31:0] dst
  );
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0:    b = IP_VER_IHL;
      5'd1:    b = 8'h00;
      5'd2:    b = tlen[15:8];
      5'd3:    b = tlen[7:0];
      5'd4:    b = ident[15:8];
      5'd5:    b = ident[7:0];
      5'd6:    b = IP_FLAGS[15:8];
      5'd7:    b = IP_FLAGS[7:0];
      5'd8:    b = ttl;
      5'd9:    b = proto;
      5'd10:   b = csum[15:8];
      5'd11:   b = csum[7:0];
      5'd12:   b = src[31:24];
      5'd13:   b = src[23:16];
      5'd14:   b = src[15:8];
      5'd15:   b = src[7:0];
      5'd16:   b = dst[31:24];
      5'd17:   b = dst[23:16];
      5'd18:   b = dst[15:8];
      5'd19:   b = dst[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Unfolded 32-bit sum of the ten header words (checksum field taken as 0).
  function automatic logic [31:0] hdr_sum(
    input logic [15:0] tlen,
    input logic [15:0] ident,
    input logic [7:0]  ttl,
    input logic [7:0]  proto,
    input logic [31:0] src,
    input logic [31:0] dst
  );
    return {16'd0, IP_VER_IHL, 8'h00} + {16'd0, tlen} + {16'd0, ident}
         + {16'd0, IP_FLAGS} + {16'd0, ttl, proto}
         + {16'd0, src[31:16]} + {16'd0, src[15:0]}
         + {16'd0, dst[31:16]} + {16'd0, dst[15:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_tx_gen_fifo_rb.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_fifo_rb
// Description : First-word-fall-through byte FIFO whose write side is
//               speculative: written bytes become visible to the reader only
//               after commit, and rollback discards everything written since
//               the last commit.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               wr_en/wr_data   - write one byte at the speculative pointer
//               commit          - publish all bytes written so far (including
//                                 a byte written in the same cycle)
//               rollback        - rewind write pointer to the last commit
//               rd_en/rd_data   - pop the head byte / head byte (FWFT)
//               full, empty     - full counts uncommitted bytes; empty only
//                                 sees committed bytes
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_fifo_rb #(
  parameter int DEPTH = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] cmt_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_inc;

  assign wr_ptr_inc = wr_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      cmt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= cmt_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (commit) begin
        cmt_ptr <= wr_en ? wr_ptr_inc : wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign full    = ((wr_ptr - rd_ptr) == DEPTH_W);
  assign empty   = (rd_ptr == cmt_ptr);

endmodule
`default_nettype wire

// File: rtl/ip_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : ip_tx_gen
// Description : IPv4 transmit framer. Buffers whole payload frames from the
//               transport layer, resolves the next hop through ARP, computes
//               the header checksum and streams a 20-byte IPv4 header plus
//               payload to the MAC TX layer with ready/valid backpressure.
//               Oversize frames are dropped and flagged on o_err_len.
// Macro       : IP_TX_LEN_CHECK_EN - when defined, frames whose byte count
//               differs from i_send_len (sampled on the first byte) are
//               dropped and flagged; otherwise i_send_len is ignored.
// Ports       : i_clk, i_rst               - clock, sync active-high reset
//               i_target_ip/_valid         - load destination IP
//               i_source_ip/_valid         - load source IP
//               i_send_*, o_send_ready     - payload ingress stream
//               o_arp_seek_ip/_valid       - ARP request pulse
//               i_arp_done                 - ARP resolved
//               o_mac_*, i_mac_ready       - frame egress stream
//               o_err_len                  - dropped-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module ip_tx_gen
  import ip_tx_pkg::*;
#(
  parameter logic [31:0] P_ST_TARGET_IP = {8'd192, 8'd168, 8'd1, 8'd0},
  parameter logic [31:0] P_ST_SOURCE_IP = {8'd192, 8'd168, 8'd1, 8'd1},
  parameter logic [7:0]  P_TTL          = 8'd64,
  parameter int          P_MAX_LEN      = 1480,
  parameter int          P_FIFO_DEPTH   = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_target_ip,
  input  logic        i_target_valid,
  input  logic [31:0] i_source_ip,
  input  logic        i_source_valid,
  input  logic [7:0]  i_send_data,
  input  logic [15:0] i_send_len,
  input  logic [7:0]  i_send_type,
  input  logic        i_send_last,
  input  logic        i_send_valid,
  output logic        o_send_ready,
  output logic [31:0] o_arp_seek_ip,
  output logic        o_arp_seek_valid,
  input  logic        i_arp_done,
  output logic [7:0]  o_mac_data,
  output logic [15:0] o_mac_len,
  output logic [15:0] o_mac_type,
  output logic        o_mac_last,
  output logic        o_mac_valid,
  input  logic        i_mac_ready,
  output logic        o_err_len
);

  localparam logic [15:0] MAX_LEN16 = P_MAX_LEN[15:0];

  // Address registers
  logic [31:0] target_ip;
  logic [31:0] source_ip;

  // Ingress state
  logic        run;
  logic [15:0] wr_cnt;
  logic [15:0] wr_cnt_nxt;
  logic        dropping;
  logic [7:0]  type_s;
  logic        accept;
  logic        first_byte;
  logic        over;
  logic        len_bad;
  logic        meta_full;
  logic [15:0] meta_len;
  logic [7:0]  meta_type;
  logic        meta_take;

  // FIFO interface
  logic        fifo_wr;
  logic        fifo_commit;
  logic        fifo_rollback;
  logic        fifo_rd;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;

  // Egress state
  state_t      state;
  logic [1:0]  cs_cnt;
  logic [31:0] sum;
  logic [15:0] csum;
  logic [15:0] ident;
  logic [7:0]  proto;
  logic [31:0] hdr_src;
  logic [31:0] hdr_dst;
  logic [4:0]  hdr_idx;
  logic [15:0] pay_len;
  logic [15:0] pay_rem;
  logic        mac_fire;

  assign o_mac_type = ETH_TYPE_IPV4;

  // --------------------------------------------------------------------------
  // IP address registers: may change at any time; the FSM snapshots them when
  // a frame is picked up, so a frame in flight is unaffected.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      target_ip <= P_ST_TARGET_IP;
      source_ip <= P_ST_SOURCE_IP;
    end else begin
      if (i_target_valid) target_ip <= i_target_ip;
      if (i_source_valid) source_ip <= i_source_ip;
    end
  end

  // --------------------------------------------------------------------------
  // Ingress. 'run' keeps ready low while reset is held.
  // --------------------------------------------------------------------------
  assign o_send_ready = run && !meta_full && !fifo_full;
  assign accept       = i_send_valid && o_send_ready;
  assign first_byte   = (wr_cnt == 16'd0) && !dropping;
  assign wr_cnt_nxt   = wr_cnt + 16'd1;
  // This byte would be number P_MAX_LEN+1 or later.
  assign over         = !dropping && (wr_cnt >= MAX_LEN16);

`ifdef IP_TX_LEN_CHECK_EN
  logic [15:0] len_s;
  assign len_bad = (wr_cnt_nxt != (first_byte ? i_send_len : len_s));
`else
  logic unused_send_len;
  assign unused_send_len = ^i_send_len;
  assign len_bad         = 1'b0;
`endif

  // Once a frame is known to be bad its bytes are swallowed without touching
  // the FIFO, so an arbitrarily long frame can never wedge on fifo_full.
  assign fifo_wr       = accept && !dropping && !over;
  assign fifo_rollback = accept && !dropping && (over || (i_send_last && len_bad));
  assign fifo_commit   = accept && i_send_last && !dropping && !over && !len_bad;
  assign meta_take     = (state == S_IDLE) && meta_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run       <= 1'b0;
      wr_cnt    <= 16'd0;
      dropping  <= 1'b0;
      type_s    <= 8'd0;
      meta_full <= 1'b0;
      meta_len  <= 16'd0;
      meta_type <= 8'd0;
      o_err_len <= 1'b0;
`ifdef IP_TX_LEN_CHECK_EN
      len_s     <= 16'd0;
`endif
    end else begin
      run       <= 1'b1;
      o_err_len <= 1'b0;
      if (meta_take) meta_full <= 1'b0;
      if (accept) begin
        if (first_byte) begin
          type_s <= i_send_type;
`ifdef IP_TX_LEN_CHECK_EN
          len_s  <= i_send_len;
`endif
        end
        if (i_send_last) begin
          wr_cnt   <= 16'd0;
          dropping <= 1'b0;
          if (fifo_commit) begin
            meta_full <= 1'b1;
            meta_len  <= wr_cnt_nxt;
            meta_type <= first_byte ? i_send_type : type_s;
          end else begin
            o_err_len <= 1'b1;
          end
        end else begin
          if (over) dropping <= 1'b1;
          if (!dropping) wr_cnt <= wr_cnt_nxt;
        end
      end
    end
  end

  ip_tx_fifo_rb #(
    .DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_en    (fifo_wr),
    .wr_data  (i_send_data),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Egress FSM. o_mac_data always holds the byte on offer; the next byte is
  // loaded on each handshake, and payload bytes are popped as they are loaded.
  // --------------------------------------------------------------------------
  assign mac_fire = o_mac_valid && i_mac_ready;
  assign fifo_rd  = mac_fire && !fifo_empty &&
                    (((state == S_HDR) && (hdr_idx == 5'd19)) ||
                     ((state == S_PAY) && !o_mac_last));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_IDLE;
      cs_cnt           <= 2'd0;
      sum              <= 32'd0;
      csum             <= 16'd0;
      ident            <= 16'd0;
      proto            <= 8'd0;
      hdr_src          <= 32'd0;
      hdr_dst          <= 32'd0;
      hdr_idx          <= 5'd0;
      pay_len          <= 16'd0;
      pay_rem          <= 16'd0;
      o_arp_seek_ip    <= 32'd0;
      o_arp_seek_valid <= 1'b0;
      o_mac_data       <= 8'd0;
      o_mac_len        <= 16'd0;
      o_mac_last       <= 1'b0;
      o_mac_valid      <= 1'b0;
    end else begin
      o_arp_seek_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (meta_full) begin
            pay_len          <= meta_len;
            o_mac_len        <= meta_len + IP_HDR_LEN;
            proto            <= meta_type;
            hdr_src          <= source_ip;
            hdr_dst          <= target_ip;
            o_arp_seek_ip    <= target_ip;
            o_arp_seek_valid <= 1'b1;
            state            <= S_ARP;
          end
        end
        S_ARP: begin
          if (i_arp_done) begin
            cs_cnt <= 2'd0;
            state  <= S_CSUM;
          end
        end
        S_CSUM: begin
          case (cs_cnt)
            2'd0: begin
              sum    <= hdr_sum(o_mac_len, ident, P_TTL, proto, hdr_src, hdr_dst);
              cs_cnt <= 2'd1;
            end
            2'd1: begin
              sum    <= {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
              cs_cnt <= 2'd2;
            end
            default: begin
              // After the first fold the sum fits in 17 bits, so one more
              // 16-bit fold cannot carry out.
              csum        <= ~(sum[15:0] + sum[31:16]);
              hdr_idx     <= 5'd0;
              o_mac_data  <= IP_VER_IHL;
              o_mac_last  <= 1'b0;
              o_mac_valid <= 1'b1;
              state       <= S_HDR;
            end
          endcase
        end
        S_HDR: begin
          if (mac_fire) begin
            if (hdr_idx == 5'd19) begin
              o_mac_data <= fifo_rdata;
              o_mac_last <= (pay_len == 16'd1);
              pay_rem    <= pay_len - 16'd1;
              state      <= S_PAY;
            end else begin
              hdr_idx    <= hdr_idx + 5'd1;
              o_mac_data <= hdr_byte(hdr_idx + 5'd1, o_mac_len, ident, P_TTL,
                                     proto, csum, hdr_src, hdr_dst);
            end
          end
        end
        S_PAY: begin
          if (mac_fire) begin
            if (o_mac_last) begin
              o_mac_valid <= 1'b0;
              o_mac_last  <= 1'b0;
              o_mac_data  <= 8'd0;
              ident       <= ident + 16'd1;
              state       <= S_IDLE;
            end else begin
              o_mac_data <= fifo_rdata;
              o_mac_last <= (pay_rem == 16'd1);
              pay_rem    <= pay_rem - 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ip_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ip_tx_gen
// Description : Self-checking bench for ip_tx_gen. Expected egress bytes are
//               queued when a frame is issued; a monitor pops and compares on
//               every MAC handshake and checks data hold under backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ip_tx_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] target_ip, source_ip;
  logic        target_valid, source_valid;
  logic [7:0]  send_data, send_type;
  logic [15:0] send_len;
  logic        send_last, send_valid, send_ready;
  logic [31:0] arp_seek_ip;
  logic        arp_seek_valid, arp_done;
  logic [7:0]  mac_data;
  logic [15:0] mac_len, mac_type;
  logic        mac_last, mac_valid, mac_ready, err_len;

  always #5 clk = ~clk;

  ip_tx_gen dut (
    .i_clk(clk), .i_rst(rst),
    .i_target_ip(target_ip), .i_target_valid(target_valid),
    .i_source_ip(source_ip), .i_source_valid(source_valid),
    .i_send_data(send_data), .i_send_len(send_len), .i_send_type(send_type),
    .i_send_last(send_last), .i_send_valid(send_valid), .o_send_ready(send_ready),
    .o_arp_seek_ip(arp_seek_ip), .o_arp_seek_valid(arp_seek_valid),
    .i_arp_done(arp_done),
    .o_mac_data(mac_data), .o_mac_len(mac_len), .o_mac_type(mac_type),
    .o_mac_last(mac_last), .o_mac_valid(mac_valid), .i_mac_ready(mac_ready),
    .o_err_len(err_len)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic [15:0] len;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0, n_fail = 0;
  int          arp_cnt = 0, err_cnt = 0, out_cnt = 0, ign_cnt = 0;
  logic [31:0] arp_ip = 32'd0;
  bit          sb_ignore = 1'b0, rand_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_data;
  logic        stall_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled at negedge, away from the active edge.
  always @(negedge clk) begin
    if (arp_seek_valid) begin
      arp_cnt++;
      arp_ip = arp_seek_ip;
    end
    if (err_len) err_cnt++;
    if (mac_valid && stall_prev) begin
      check("hold_data", {24'd0, mac_data}, {24'd0, stall_data});
      check("hold_last", {31'd0, mac_last}, {31'd0, stall_last});
    end
    stall_prev = mac_valid && !mac_ready;
    stall_data = mac_data;
    stall_last = mac_last;
    if (mac_valid && mac_ready) begin
      if (sb_ignore) begin
        ign_cnt++;
      end else begin
        out_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected none", mac_data);
        end else begin
          e = sb.pop_front();
          check("mac_data", {24'd0, mac_data}, {24'd0, e.data});
          check("mac_last", {31'd0, mac_last}, {31'd0, e.last});
          check("mac_len",  {16'd0, mac_len},  {16'd0, e.len});
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) mac_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [15:0] csum_model(input logic [15:0] tlen, input logic [15:0] id,
                                             input logic [7:0] proto,
                                             input logic [31:0] src, input logic [31:0] dst);
    logic [31:0] s;
    s = 32'h4500 + 32'(tlen) + 32'(id) + 32'h4000 + {24'd64, 8'd0} + 32'(proto)
      + 32'(src[31:16]) + 32'(src[15:0]) + 32'(dst[31:16]) + 32'(dst[15:0]);
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  task automatic push_raw(input logic [7:0] bytes[$]);
    exp_t x;
    for (int i = 0; i < bytes.size(); i++) begin
      x.data = bytes[i];
      x.last = (i == bytes.size() - 1);
      x.len  = 16'(bytes.size());
      sb.push_back(x);
    end
  endtask

  task automatic push_frame(input logic [7:0] pay[$], input logic [7:0] proto,
                            input logic [15:0] id, input logic [31:0] src, input logic [31:0] dst);
    logic [7:0]  b[$];
    logic [15:0] tl, cs;
    tl = 16'(pay.size() + 20);
    cs = csum_model(tl, id, proto, src, dst);
    b = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00, 8'd64, proto,
          cs[15:8], cs[7:0], src[31:24], src[23:16], src[15:8], src[7:0],
          dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
    for (int i = 0; i < pay.size(); i++) b.push_back(pay[i]);
    push_raw(b);
  endtask

  // Called and returns at posedge+1.
  task automatic send_frame(input logic [7:0] pay[$], input logic [7:0] typ, input logic [15:0] dlen);
    int n;
    for (int i = 0; i < pay.size(); i++) begin
      send_data  = pay[i];
      send_last  = (i == pay.size() - 1);
      send_len   = dlen;
      send_type  = typ;
      send_valid = 1'b1;
      n = 0;
      while (!send_ready && n < 5000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 5000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d not accepted", i);
      end
      @(posedge clk); #1;
    end
    send_valid = 1'b0;
    send_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || mac_valid) && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [7:0]  pay8[$], pay9[$], payA[$], payB[$], payS[$], payO[$];
  logic [7:0]  basic0[$], basic1[$], basic2[$];
  logic [31:0] def_src, def_dst;
  int          a0, e0, o0, n;
  bit          seen;
  logic [15:0] next_id;

  initial begin
    def_src = 32'hC0A80101;
    def_dst = 32'hC0A80100;
    pay8 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    pay9 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    payA = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    payB = '{8'h11, 8'h22, 8'h33};
    payS = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 1481; i++) payO.push_back(8'(i));
    // Hand-computed frames for the 8-byte payload, proto 0x11, ident 0/1/2.
    basic0 = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB7, 8'h7F, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    basic1 = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB7, 8'h7E, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    basic2 = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h02, 8'h40, 8'h00, 8'h40, 8'h11,
               8'hB7, 8'h7D, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    rst = 1'b1; target_ip = 32'd0; source_ip = 32'd0; target_valid = 1'b0; source_valid = 1'b0;
    send_data = 8'd0; send_type = 8'd0; send_len = 16'd0; send_last = 1'b0; send_valid = 1'b0;
    arp_done = 1'b1; mac_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mac_valid", {31'd0, mac_valid}, 0);
    check("rst_mac_type", {16'd0, mac_type}, 32'h0800);
    check("rst_mac_len", {16'd0, mac_len}, 0);
    check("rst_send_ready", {31'd0, send_ready}, 0);
    check("rst_arp_valid", {31'd0, arp_seek_valid}, 0);
    check("rst_err_len", {31'd0, err_len}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, send_ready}, 1);

    // Basic frame, then identification increments
    push_raw(basic0);
    send_frame(pay8, 8'h11, 16'd8);
    wait_drain("t1_drain");
    check("t1_arp_cnt", arp_cnt, 1);
    check("t1_arp_ip", arp_ip, 32'hC0A80100);
    check("t1_out_cnt", out_cnt, 28);
    push_raw(basic1);
    send_frame(pay8, 8'h11, 16'd8);
    wait_drain("t2_drain");

    // Random MAC backpressure
    rand_ready = 1'b1;
    push_raw(basic2);
    send_frame(pay8, 8'h11, 16'd8);
    wait_drain("t3_drain");
    rand_ready = 1'b0;
    mac_ready  = 1'b1;
    @(posedge clk); #1;
    mac_ready  = 1'b1;
    check("t3_out_cnt", out_cnt, 84);

    // Delayed ARP; second frame buffered during the wait
    arp_done = 1'b0;
    a0 = arp_cnt;
    push_frame(payA, 8'h01, 16'd3, def_src, def_dst);
    push_frame(payB, 8'h06, 16'd4, def_src, def_dst);
    send_frame(payA, 8'h01, 16'd4);
    send_frame(payB, 8'h06, 16'd3);
    check("t4_ready_low_after_b", {31'd0, send_ready}, 0);
    check("t4_arp_a", arp_cnt, a0 + 1);
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (mac_valid) seen = 1'b1;
    end
    check("t4_valid_during_wait", {31'd0, seen}, 0);
    arp_done = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("t4_valid_latency", {31'd0, mac_valid}, (k == 4) ? 1 : 0);
    end
    wait_drain("t4_drain");
    check("t4_arp_b", arp_cnt, a0 + 2);

    // Oversize frame dropped, next frame fine
    e0 = err_cnt;
    o0 = out_cnt;
    send_frame(payO, 8'h11, 16'd1481);
    repeat (20) @(posedge clk);
    #1;
    check("t5_err_pulse", err_cnt, e0 + 1);
    check("t5_no_output", out_cnt, o0);
    push_frame(payS, 8'h11, 16'd5, def_src, def_dst);
    send_frame(payS, 8'h11, 16'd4);
    wait_drain("t5_drain");

    // Reset during payload
    sb_ignore = 1'b1;
    ign_cnt = 0;
    send_frame(pay8, 8'h11, 16'd8);
    n = 0;
    while (ign_cnt < 22 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reached_pay", {31'd0, (ign_cnt >= 22)}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_in_reset", {31'd0, mac_valid}, 0);
    check("t6_fifo_empty", {31'd0, dut.u_fifo.empty}, 1);
    rst = 1'b0;
    sb_ignore = 1'b0;
    @(posedge clk); #1;
    push_raw(basic0);
    send_frame(pay8, 8'h11, 16'd8);
    wait_drain("t6_drain");
    next_id = 16'd1;

    // Declared length mismatch (9 bytes, length field 10)
    e0 = err_cnt;
    o0 = out_cnt;
`ifdef IP_TX_LEN_CHECK_EN
    send_frame(pay9, 8'h11, 16'd10);
    repeat (20) @(posedge clk);
    #1;
    check("t7_err_pulse", err_cnt, e0 + 1);
    check("t7_no_output", out_cnt, o0);
`else
    push_frame(pay9, 8'h11, next_id, def_src, def_dst);
    send_frame(pay9, 8'h11, 16'd10);
    wait_drain("t7_drain");
    check("t7_no_err", err_cnt, e0);
    check("t7_out_cnt", out_cnt, o0 + 29);
    next_id = next_id + 16'd1;
`endif

    // New addresses take effect on the next frame
    target_ip = 32'h0A000002; target_valid = 1'b1;
    source_ip = 32'h0A000001; source_valid = 1'b1;
    @(posedge clk); #1;
    target_valid = 1'b0; source_valid = 1'b0;
    push_frame(payS, 8'h06, next_id, 32'h0A000001, 32'h0A000002);
    send_frame(payS, 8'h06, 16'd4);
    wait_drain("t8_drain");
    check("t8_arp_ip", arp_ip, 32'h0A000002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_tx_gen.md
Name: ip_tx_gen

Overview:
Parametrised successor IPv4 transmit block: store-and-forward framing with ready/valid backpressure on both sides, ARP-resolution wait, and oversize-frame drop.
- Accepts payload bytes plus protocol from the UDP/ICMP layer and buffers each whole frame.
- Resolves the next hop through ARP, then emits a 20-byte IPv4 header followed by the payload to the MAC TX layer.
- Sits between the transport layer and mac_tx in the UDP stack.

Parameters:
P_ST_TARGET_IP, {8'd192,8'd168,8'd1,8'd0}, target IP after reset
P_ST_SOURCE_IP, {8'd192,8'd168,8'd1,8'd1}, source IP after reset
P_TTL, 8'd64, time-to-live field
P_MAX_LEN, 1480, maximum payload bytes per frame
P_FIFO_DEPTH, 2048, payload buffer bytes; power of 2, must be >= P_MAX_LEN

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_target_ip  in  32  new target IP
i_target_valid  in  1  load i_target_ip
i_source_ip  in  32  new source IP
i_source_valid  in  1  load i_source_ip
i_send_data  in  8  payload byte
i_send_len  in  16  declared payload length, sampled on first byte
i_send_type  in  8  IP protocol, sampled on first byte
i_send_last  in  1  last payload byte
i_send_valid  in  1  byte valid
o_send_ready  out  1  byte accepted when valid&ready
o_arp_seek_ip  out  32  IP to resolve
o_arp_seek_valid  out  1  one-cycle request pulse
i_arp_done  in  1  ARP resolved (level or pulse)
o_mac_data  out  8  frame byte
o_mac_len  out  16  IP total length (payload+20)
o_mac_type  out  16  constant 16'h0800
o_mac_last  out  1  last frame byte
o_mac_valid  out  1  frame byte valid
i_mac_ready  in  1  MAC accepts byte
o_err_len  out  1  one-cycle pulse on dropped frame

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: all outputs 0 except o_mac_type=16'h0800. IPs load from the parameters; identification=0; FIFO empty; FSM=IDLE.
- IP registers: load on *_valid in any state. The values are sampled into the header at S_ARP entry, so a mid-frame change does not affect the frame in flight.
- Ingress:
  - o_send_ready = !meta_full && !fifo_full.
  - Each accepted byte is written and counted in 16-bit wr_cnt.
  - On accepted last byte, {wr_cnt+1, type} is committed to a single metadata slot and the write pointer is committed; meta_full is set.
- Oversize drop: if a frame's byte count exceeds P_MAX_LEN, the write pointer rolls back to its last committed value and o_err_len pulses. Bytes up to and including last are still accepted and discarded.
- FSM:
  - IDLE: when meta_full, latch metadata, clear meta_full, pulse o_arp_seek_valid with o_arp_seek_ip=target; go to ARP.
  - ARP: wait for i_arp_done, then go to CSUM.
  - CSUM: exactly 3 cycles:
    - cycle 1: 32-bit sum of the ten header words {4500, total_len, ident, 4000, {P_TTL,proto}, src_hi, src_lo, dst_hi, dst_lo};
    - cycle 2: fold;
    - cycle 3: fold and invert.
    Then go to HDR.
  - HDR: 20 bytes in order 45,00,len_hi,len_lo,id_hi,id_lo,40,00,TTL,proto,csum_hi,csum_lo,src[31:24..7:0],dst[31:24..7:0]. Then go to PAY.
  - PAY: payload bytes read from the FIFO. o_mac_last is asserted with the final byte; after its handshake, ident+1 (wraps at 16'hFFFF to 0) and return to IDLE.
- Egress handshake:
  - o_mac_valid is held high throughout HDR and PAY.
  - A byte advances only on o_mac_valid && i_mac_ready.
  - o_mac_data, o_mac_last and o_mac_len are stable while valid && !ready.
- Zero-length frame (last on first byte with no payload): not allowed. Every frame carries at least 1 byte, since the last byte is itself a payload byte.
- Overlap: a new frame is accepted into the FIFO while the previous one transmits. Its metadata is committed only once the slot frees; if the slot is still occupied, o_send_ready stays low after that frame's last byte.
- FIFO full mid-frame: backpressure via o_send_ready; no loss.

Optional Feature:
IP_TX_LEN_CHECK_EN
- Defined: a frame whose counted bytes != sampled i_send_len is rolled back and dropped, with o_err_len pulsing one cycle after its last byte.
- Undefined: i_send_len is ignored and the counted length is used for the header.

Decomposition:
- Package ip_tx_pkg holds: FSM state enum (S_IDLE, S_ARP, S_CSUM, S_HDR, S_PAY); constants IP_HDR_LEN=20, ETH_TYPE_IPV4=16'h0800, IP_VER_IHL=8'h45, IP_FLAGS=16'h4000.
- Sub-module ip_tx_fifo_rb: FWFT byte FIFO with commit/rollback write pointer; depth P_FIFO_DEPTH.

Test Plan:
- Basic frame, using default IPs, 8-byte payload 01..08, proto 8'h11, i_arp_done tied high, i_mac_ready=1:
  - o_arp_seek_valid pulses once with C0A80100;
  - 28 bytes out, with o_mac_len=001C and checksum bytes B7,7F;
  - last byte 08 with o_mac_last;
  - next frame carries id=0001.
- Random i_mac_ready (50% duty): byte order and count identical to the basic case; o_mac_data is held while valid&&!ready.
- i_arp_done delayed 100 cycles: o_mac_valid stays 0 until 4 cycles after i_arp_done (ARP exit plus 3 CSUM cycles); a second frame is fully buffered during the wait and o_send_ready drops after its last byte.
- Frame of P_MAX_LEN+1 bytes: o_err_len pulses, no output frame, and a following 4-byte frame is sent correctly.
- Reset asserted mid-PAY: the next cycle shows o_mac_valid=0 and the FIFO empty; after release, a new frame goes out with id=0000.
- With IP_TX_LEN_CHECK_EN: i_send_len=10 with 9 bytes sent → o_err_len pulses and no frame is emitted. Without the macro, the frame goes out with o_mac_len=001D (9 bytes + 20).
